// File: rtl/uart_boot_loader.sv
// Boot loader: turns the UART RX byte stream (A5, LEN, LEN words LSB-first, CSUM) into imem writes and CPU release.
// Latency: imem write 1 cycle after a word's last byte strobe; done/err 1 cycle after the CSUM strobe.
// Backpressure: none; one byte per rising edge of rx valid, inter-byte stalls bounded by the timeout.
module uart_boot_loader #(
    parameter int                    ADDR_WIDTH     = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter logic [7:0]            HEADER_BYTE    = 8'hA5,
    parameter int                    TIMEOUT_CYCLES = 1000000
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [31:0]           o_mem_wdata,
    output logic                  o_cpu_hold,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4
    } state_t;

    state_t                state;
    logic                  valid_q;
    logic                  byte_stb;
    logic [15:0]           len;
    logic [15:0]           widx;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [1:0]            bidx;
    logic [23:0]           wbuf;
    logic [7:0]            sum;
    logic [TW-1:0]         tcnt;

    // Valid is a level that may stay high for many cycles; only its rising edge carries a byte.
    assign byte_stb = i_rx_valid & ~valid_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= IDLE;
            valid_q     <= 1'b0;
            len         <= '0;
            widx        <= '0;
            waddr       <= BASE_ADDR;
            bidx        <= '0;
            wbuf        <= '0;
            sum         <= '0;
            tcnt        <= '0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= BASE_ADDR;
            o_mem_wdata <= '0;
            o_cpu_hold  <= 1'b1;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            valid_q  <= i_rx_valid;
            o_mem_we <= 1'b0;

            // A strobe landing on the terminal count still counts as activity.
            if (state != IDLE) begin
                if (byte_stb) begin
                    tcnt <= '0;
                end else if (tcnt == TO_LAST) begin
                    tcnt       <= '0;
                    state      <= IDLE;
                    o_busy     <= 1'b0;
                    o_err      <= 1'b1;
                    o_cpu_hold <= 1'b1;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end

            if (byte_stb) begin
                case (state)
                    IDLE: begin
                        if (i_rx_data == HEADER_BYTE) begin
                            state      <= LEN_LO;
                            o_busy     <= 1'b1;
                            o_cpu_hold <= 1'b1;
                            o_done     <= 1'b0;
                            o_err      <= 1'b0;
                            sum        <= '0;
                            widx       <= '0;
                            waddr      <= BASE_ADDR;
                            bidx       <= '0;
                            tcnt       <= '0;
                        end
                    end
                    LEN_LO: begin
                        len[7:0] <= i_rx_data;
                        sum      <= sum + i_rx_data;
                        state    <= LEN_HI;
                    end
                    LEN_HI: begin
                        len[15:8] <= i_rx_data;
                        sum       <= sum + i_rx_data;
                        state     <= ({i_rx_data, len[7:0]} != 16'd0) ? DATA : CSUM;
                    end
                    DATA: begin
                        sum  <= sum + i_rx_data;
                        bidx <= bidx + 1'b1;
                        if (bidx == 2'd3) begin
                            o_mem_we    <= 1'b1;
                            o_mem_addr  <= waddr;
                            o_mem_wdata <= {i_rx_data, wbuf};
                            waddr       <= waddr + 1'b1;
                            widx        <= widx + 16'd1;
                            if (widx == len - 16'd1) begin
                                state <= CSUM;
                            end
                        end else begin
                            // Bytes enter at the top so the first byte ends up in bits 7:0.
                            wbuf <= {i_rx_data, wbuf[23:8]};
                        end
                    end
                    CSUM: begin
                        if (i_rx_data == sum) begin
                            o_done     <= 1'b1;
                            o_cpu_hold <= 1'b0;
                        end else begin
                            o_err <= 1'b1;
                        end
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Bench for uart_boot_loader: byte-stream model predicts writes and final status, checked every cycle.
`timescale 1ns/1ps
module tb_uart_boot_loader;

    localparam int             AW   = 4;
    localparam logic [AW-1:0]  BASE = '0;
    localparam int             T    = 100;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b1;
    logic [7:0]      i_rx_data = 8'h00;
    logic            i_rx_valid = 1'b0;
    logic            o_mem_we;
    logic [AW-1:0]   o_mem_addr;
    logic [31:0]     o_mem_wdata;
    logic            o_cpu_hold;
    logic            o_busy;
    logic            o_done;
    logic            o_err;

    uart_boot_loader #(
        .ADDR_WIDTH(AW),
        .BASE_ADDR(BASE),
        .HEADER_BYTE(8'hA5),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .i_rx_data(i_rx_data),
        .i_rx_valid(i_rx_valid),
        .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata),
        .o_cpu_hold(o_cpu_hold),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_err(o_err)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [15:0]   pos;
    } wr_t;

    int          nerr = 0;
    int          nchk = 0;
    logic [7:0]  pkt[$];
    wr_t         exp_q[$];
    logic        exp_good;
    logic        mdl_done = 1'b0;
    logic        mdl_err = 1'b0;
    int          last_pos = -1;
    int          last_stb = 0;
    logic        we_prev = 1'b0;
    logic [31:0] seen_data[$];
    logic [AW-1:0] seen_addr[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: of the first 'upto' bytes the loader accepts, every complete word becomes one write;
    // the load is good only when the whole packet arrived and its last byte is the byte sum.
    task automatic model_packet(input int upto);
        int         len;
        logic [7:0] s;
        wr_t        e;
        len = (upto >= 3) ? int'({pkt[2], pkt[1]}) : 0;
        for (int i = 0; i < len; i++) begin
            if (3 + 4*i + 3 < upto) begin
                e.addr = AW'((int'(BASE) + i) % (1 << AW));
                e.data = {pkt[3+4*i+3], pkt[3+4*i+2], pkt[3+4*i+1], pkt[3+4*i]};
                e.pos  = 16'(3 + 4*i + 3);
                exp_q.push_back(e);
            end
        end
        s = 8'h00;
        for (int k = 1; k < pkt.size() - 1; k++) s = s + pkt[k];
        exp_good = (upto == pkt.size()) && (pkt.size() == 4 + 4*len) && (pkt[pkt.size()-1] == s);
    endtask

    // Raise valid for 'hi' edges, then drop it for 'lo' edges; strobe spacing is hi+lo+1.
    task automatic send_byte(input logic [7:0] d, input int pos, input int hi, input int lo);
        @(posedge i_clk); #1;
        i_rx_data  = d;
        i_rx_valid = 1'b1;
        last_pos   = pos;
        @(posedge i_clk); #1;
        last_stb = cyc;
        repeat (hi - 1) begin @(posedge i_clk); #1; end
        i_rx_valid = 1'b0;
        repeat (lo) begin @(posedge i_clk); #1; end
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin @(posedge i_clk); #1; end
    endtask

    task automatic send_packet(input int hmin, input int hmax, input int lmax,
                               input int slow_idx, input int slow_lo);
        int hi, lo;
        for (int k = 0; k < pkt.size(); k++) begin
            hi = $urandom_range(hmax, hmin);
            lo = $urandom_range(lmax, 0);
            if (k == slow_idx) begin hi = 1; lo = slow_lo; end
            send_byte(pkt[k], k, hi, lo);
            if (k == 0) begin
                chk("hdr_busy", 32'(o_busy), 32'd1);
                chk("hdr_hold", 32'(o_cpu_hold), 32'd1);
                chk("hdr_done", 32'(o_done), 32'd0);
                chk("hdr_err",  32'(o_err), 32'd0);
            end
        end
    endtask

    task automatic finish_packet(input string tag);
        repeat (2) begin @(posedge i_clk); #1; end
        chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_done"}, 32'(o_done), 32'(exp_good));
        chk({tag, "_err"},  32'(o_err),  32'(!exp_good));
        chk({tag, "_hold"}, 32'(o_cpu_hold), 32'(!exp_good));
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        mdl_done = exp_good;
        mdl_err  = !exp_good;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_done"}, 32'(o_done), 32'(mdl_done));
        chk({tag, "_err"},  32'(o_err),  32'(mdl_err));
        chk({tag, "_hold"}, 32'(o_cpu_hold), 32'(!mdl_done));
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
    endtask

    task automatic build_random(input int len, input bit good);
        logic [7:0] s, b;
        pkt.delete();
        pkt.push_back(8'hA5);
        pkt.push_back(8'(len));
        pkt.push_back(8'(len >> 8));
        s = 8'(len) + 8'(len >> 8);
        for (int i = 0; i < 4*len; i++) begin
            b = ($urandom_range(7, 0) == 0) ? 8'hA5 : 8'($urandom);
            pkt.push_back(b);
            s = s + b;
        end
        pkt.push_back(good ? s : (s ^ 8'h01));
    endtask

    // Every cycle: each write must be the next predicted one, one cycle wide, right after its byte.
    always @(negedge i_clk) begin
        wr_t e;
        if (i_rst_n) begin
            if (o_mem_we) begin
                chk("we_pulse_width", 32'(we_prev), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 32'(o_mem_addr), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(o_mem_addr), 32'(e.addr));
                    chk("wr_data", o_mem_wdata, e.data);
                    chk("wr_after_byte", 32'(last_pos), 32'(e.pos));
                    chk("wr_latency", 32'(cyc), 32'(last_stb));
                end
                seen_addr.push_back(o_mem_addr);
                seen_data.push_back(o_mem_wdata);
            end
            if (o_done) chk("done_excl", {29'd0, o_err, o_cpu_hold, o_busy}, 32'd0);
        end
        we_prev = o_mem_we;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 i_rst_n = 1'b0;
        #1;
        chk("rst_we",    32'(o_mem_we), 32'd0);
        chk("rst_addr",  32'(o_mem_addr), 32'(BASE));
        chk("rst_wdata", o_mem_wdata, 32'd0);
        chk("rst_hold",  32'(o_cpu_hold), 32'd1);
        chk("rst_busy",  32'(o_busy), 32'd0);
        chk("rst_done",  32'(o_done), 32'd0);
        chk("rst_err",   32'(o_err), 32'd0);
        #20 i_rst_n = 1'b1;

        // 1: nominal two-word load.
        pkt = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h66};
        model_packet(pkt.size());
        chk("model_s1_good", 32'(exp_good), 32'd1);
        seen_addr.delete(); seen_data.delete();
        send_packet(1, 3, 3, -1, 0);
        finish_packet("s1");
        chk("s1_nwrites", 32'(seen_data.size()), 32'd2);
        if (seen_data.size() == 2) begin
            chk("s1_w0_addr", 32'(seen_addr[0]), 32'd0);
            chk("s1_w0_data", seen_data[0], 32'h44332211);
            chk("s1_w1_addr", 32'(seen_addr[1]), 32'd1);
            chk("s1_w1_data", seen_data[1], 32'h88776655);
        end
        chk("s1_done_lit", 32'(o_done), 32'd1);
        chk("s1_hold_lit", 32'(o_cpu_hold), 32'd0);

        // 2: bad checksum after the writes.
        pkt[11] = 8'h67;
        model_packet(pkt.size());
        chk("model_s2_good", 32'(exp_good), 32'd0);
        send_packet(1, 3, 3, -1, 0);
        finish_packet("s2");
        chk("s2_err_lit", 32'(o_err), 32'd1);

        // 3: noise before header is ignored, then an empty load.
        send_byte(8'h00, -1, 2, 2);
        send_byte(8'h5A, -1, 2, 2);
        check_idle("s3_noise");
        pkt = '{8'hA5, 8'h00, 8'h00, 8'h00};
        model_packet(pkt.size());
        send_packet(1, 3, 3, -1, 0);
        finish_packet("s3");

        // 4: valid held high for a long time per byte.
        pkt = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h66};
        model_packet(pkt.size());
        send_packet(60, 60, 3, -1, 0);
        finish_packet("s4");

        // 5: timeout with a word half received, exact abort cycle.
        pkt = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        model_packet(pkt.size());
        send_packet(2, 2, 1, -1, 0);
        wait_until(last_stb + T - 1);
        chk("s5_busy_before_to", 32'(o_busy), 32'd1);
        chk("s5_err_before_to",  32'(o_err), 32'd0);
        wait_until(last_stb + T);
        chk("s5_busy_after_to", 32'(o_busy), 32'd0);
        chk("s5_err_after_to",  32'(o_err), 32'd1);
        chk("s5_hold_after_to", 32'(o_cpu_hold), 32'd1);
        finish_packet("s5");

        // Boundary: strobe exactly on the terminal count survives; one cycle later aborts.
        pkt = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h39};
        model_packet(pkt.size());
        send_packet(1, 2, 2, 3, T - 2);
        finish_packet("to_edge_ok");
        model_packet(4);
        send_packet(1, 2, 2, 3, T - 1);
        finish_packet("to_edge_abort");

        // 6: reset after first word, then full reload.
        pkt = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        model_packet(pkt.size());
        send_packet(1, 3, 3, -1, 0);
        @(posedge i_clk); #3;
        i_rst_n = 1'b0;
        #1;
        chk("s6_pending_writes", 32'(exp_q.size()), 32'd0);
        chk("s6_rst_we",    32'(o_mem_we), 32'd0);
        chk("s6_rst_addr",  32'(o_mem_addr), 32'(BASE));
        chk("s6_rst_wdata", o_mem_wdata, 32'd0);
        chk("s6_rst_hold",  32'(o_cpu_hold), 32'd1);
        chk("s6_rst_busy",  32'(o_busy), 32'd0);
        chk("s6_rst_done",  32'(o_done), 32'd0);
        chk("s6_rst_err",   32'(o_err), 32'd0);
        #12 i_rst_n = 1'b1;
        pkt = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h66};
        model_packet(pkt.size());
        send_packet(1, 3, 3, -1, 0);
        finish_packet("s6");

        // Randomized loads: lengths past 2^AW words wrap the address, mixed checksums and noise.
        for (int p = 0; p < 25; p++) begin
            int  len, ng;
            bit  good;
            logic [7:0] d;
            ng = $urandom_range(3, 0);
            for (int g = 0; g < ng; g++) begin
                d = 8'($urandom);
                if (d == 8'hA5) d = 8'h5A;
                send_byte(d, -1, $urandom_range(4, 1), $urandom_range(4, 0));
            end
            if (ng != 0) check_idle("rnd_noise");
            len  = $urandom_range(20, 0);
            good = 1'($urandom_range(1, 0));
            build_random(len, good);
            model_packet(pkt.size());
            chk("rnd_model_good", 32'(exp_good), 32'(good));
            send_packet(1, 4, 4, -1, 0);
            finish_packet("rnd");
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
